// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FIFO-fed UART transmitter:
//   uart_state_e   : transmitter FSM state encoding
//   FRAME_OVERHEAD : non-data bits per frame (one start bit plus one stop bit)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    START   = 3'd2,
    DATA    = 3'd3,
    STOP    = 3'd4
  } uart_state_e;

  localparam int FRAME_OVERHEAD = 2;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// FIFO read-side bundle between a synchronous FIFO and the UART transmitter.
// Signal names are taken from the transmitter's point of view.
//   fifo_dout_i  : read data, valid the cycle after a read strobe
//   fifo_empty_i : FIFO empty flag
//   fifo_rd_en_o : single-cycle pop strobe
// Modports:
//   master : the FIFO (drives data and empty, receives the pop strobe)
//   slave  : the transmitter (consumes data and empty, drives the pop strobe)
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if #(
  parameter int width = 8
);

  logic [width-1:0] fifo_dout_i;
  logic             fifo_empty_i;
  logic             fifo_rd_en_o;

  modport master (
    output fifo_dout_i,
    output fifo_empty_i,
    input  fifo_rd_en_o
  );

  modport slave (
    input  fifo_dout_i,
    input  fifo_empty_i,
    output fifo_rd_en_o
  );

endinterface

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Bit-period timer. While enabled it counts 0..clks_per_bit-1 and wraps.
//   clk_i      : system clock
//   reset_i    : synchronous active-high reset
//   enable_i   : count while high; counter is held at zero while low
//   tick_o     : high on the last cycle of each bit period (bit boundary)
//   pre_tick_o : high on the cycle before tick_o, so the parent can register
//                a flag that lines up with the last cycle of a bit
// clks_per_bit must be at least 2.
// -----------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int clks_per_bit = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  output logic tick_o,
  output logic pre_tick_o
);

  localparam int CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam logic [CW-1:0] LAST = CW'(clks_per_bit - 1);
  localparam logic [CW-1:0] PRE  = CW'(clks_per_bit - 2);

  logic [CW-1:0] cnt;

  // NOTE: state is updated with <= so every register samples pre-edge values;
  // a blocking = here would let later statements see the new value mid-block.
  always_ff @(posedge clk_i) begin
    if (reset_i || !enable_i) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick_o     = enable_i && (cnt == LAST);
  assign pre_tick_o = enable_i && (cnt == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Pops words from a synchronous FIFO and sends each one as a UART frame:
// one low start bit, width data bits LSB first, one high stop bit, every bit
// held for clks_per_bit cycles.
//   clk_i        : system clock, rising edge
//   reset_i      : synchronous active-high reset, dominates everything
//   fifo         : FIFO read side (slave modport: dout/empty in, rd_en out)
//   tx_o         : registered serial line, idle high
//   busy_o       : high from the fetch (CAPTURE) until the end of the stop bit
//   frame_done_o : one-cycle pulse on the last cycle of the stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int width        = 8,
  parameter int clks_per_bit = 16
) (
  input  logic           clk_i,
  input  logic           reset_i,
  fifo_uart_tx_if.slave  fifo,
  output logic           tx_o,
  output logic           busy_o,
  output logic           frame_done_o
);

  localparam int BW = (width > 1) ? $clog2(width) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(width - 1);

  uart_state_e      state;
  logic [width-1:0] shift;
  logic [BW-1:0]    bit_idx;
  logic             tick;
  logic             pre_tick;
  logic             baud_en;

  // The pop strobe is combinational so the FIFO sees it in the same cycle the
  // FSM decides to leave IDLE; the state change on that edge ends the pulse.
  assign fifo.fifo_rd_en_o = (state == IDLE) && !fifo.fifo_empty_i && !reset_i;

  // The bit timer runs only while a frame is on the line, so it always starts
  // a fresh bit period at the first start-bit cycle.
  assign baud_en = (state == START) || (state == DATA) || (state == STOP);

  baud_tick_gen #(
    .clks_per_bit (clks_per_bit)
  ) u_baud (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .enable_i   (baud_en),
    .tick_o     (tick),
    .pre_tick_o (pre_tick)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      shift        <= '0;
      bit_idx      <= '0;
      tx_o         <= 1'b1;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo.fifo_empty_i) begin
            state  <= CAPTURE;
            busy_o <= 1'b1;
          end
        end
        // Popped word is on fifo_dout_i during this cycle.
        CAPTURE: begin
          shift <= fifo.fifo_dout_i;
          tx_o  <= 1'b0;
          state <= START;
        end
        START: begin
          if (tick) begin
            tx_o    <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              tx_o  <= 1'b1;
              state <= STOP;
            end else begin
              // tx_o takes the next bit directly so it changes on the same
              // edge as the shift, without waiting a cycle for shift[0].
              shift   <= shift >> 1;
              tx_o    <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (pre_tick) begin
            frame_done_o <= 1'b1;
          end
          if (tick) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Self-checking bench for fifo_uart_tx (width=8, clks_per_bit=4, 20 ns clock)
// with a behavioural FIFO whose pop data appears the cycle after the strobe.
// Expected serial lines are hand-written 10-bit frames, bit 0 = start bit,
// bits 8:1 = data LSB first, bit 9 = stop bit.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;
  import uart_pkg::*;

  localparam int W           = 8;
  localparam int CPB         = 4;
  localparam int FRAME_LEN   = (W + FRAME_OVERHEAD) * CPB;
  localparam int WAIT_BUDGET = 200;

  logic clk_i = 1'b0;
  logic reset_i;
  logic tx_o;
  logic busy_o;
  logic frame_done_o;

  fifo_uart_tx_if #(.width(W)) bus ();

  fifo_uart_tx #(
    .width        (W),
    .clks_per_bit (CPB)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .fifo         (bus),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  always #10 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
    string      name;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] q[$];
  int         pops;
  int         passed;
  int         total;
  bit         noise_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock: sample the pop strobe before the edge, then act as the FIFO
  // after the edge and leave time for combinational outputs to settle.
  task automatic step();
    logic rd;
    rd = bus.fifo_rd_en_o;
    @(posedge clk_i);
    #1;
    if (rd === 1'b1) begin
      pops++;
      if (q.size() > 0) bus.fifo_dout_i = q.pop_front();
    end
    if (noise_en) begin
      bus.fifo_empty_i = 1'($urandom_range(0, 1));
      bus.fifo_dout_i  = 8'($urandom);
    end else begin
      bus.fifo_empty_i = (q.size() == 0);
    end
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    if (!noise_en) bus.fifo_empty_i = 1'b0;
    #1;
  endtask

  // Waits for the pop strobe, then records and checks one complete frame.
  task automatic run_frame(input string name, input logic [7:0] data,
                           input logic [9:0] line, input bit noisy,
                           output int waited);
    logic [FRAME_LEN-1:0] obs_tx;
    logic [FRAME_LEN-1:0] obs_done;
    logic [FRAME_LEN-1:0] exp_tx;
    logic [FRAME_LEN-1:0] exp_done;
    logic                 busy_all;
    logic [7:0]           dec;
    int                   pops0;

    waited = 0;
    while (bus.fifo_rd_en_o !== 1'b1 && waited < WAIT_BUDGET) begin
      step();
      waited++;
    end
    check({name, " rd_en seen"}, 64'(bus.fifo_rd_en_o), 64'd1);

    pops0 = pops;
    step();
    check({name, " capture busy/tx/rd"}, {busy_o, tx_o, bus.fifo_rd_en_o}, 3'b110);
    step();

    noise_en = noisy;
    busy_all = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      obs_tx[i]   = tx_o;
      obs_done[i] = frame_done_o;
      busy_all    = busy_all & busy_o;
      if (i == FRAME_LEN - 3) noise_en = 1'b0;
      step();
    end

    for (int i = 0; i < FRAME_LEN; i++) exp_tx[i] = line[i / CPB];
    exp_done = '0;
    exp_done[FRAME_LEN-1] = 1'b1;
    for (int b = 0; b < 8; b++) dec[b] = obs_tx[CPB * (b + 1) + CPB / 2];

    check({name, " tx line"}, 64'(obs_tx), 64'(exp_tx));
    check({name, " frame_done"}, 64'(obs_done), 64'(exp_done));
    check({name, " busy during frame"}, 64'(busy_all), 64'd1);
    check({name, " decoded byte"}, 64'(dec), 64'(data));
    check({name, " after frame busy/done/tx"}, {busy_o, frame_done_o, tx_o}, 3'b001);
    check({name, " pops"}, 64'(pops - pops0), 64'd1);
  endtask

  initial begin
    int w;
    int w2;
    int bad;
    int pops0;

    passed           = 0;
    total            = 0;
    pops             = 0;
    noise_en         = 1'b0;
    reset_i          = 1'b1;
    bus.fifo_empty_i = 1'b1;
    bus.fifo_dout_i  = '0;

    vecs[0] = '{8'hF0, 10'h3E0, "f0"};
    vecs[1] = '{8'h00, 10'h200, "00"};
    vecs[2] = '{8'hFF, 10'h3FE, "ff"};
    vecs[3] = '{8'h55, 10'h2AA, "55"};

    #1;
    // Reset held with data waiting: no pop, line idle.
    push(8'hF0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset hold rd/tx/busy/done",
            {bus.fifo_rd_en_o, tx_o, busy_o, frame_done_o}, 4'b0100);
    end
    reset_i = 1'b0;
    #1;
    check("rd_en right after reset release", 64'(bus.fifo_rd_en_o), 64'd1);

    // Single frames from the table (0xF0 is already queued).
    for (int v = 0; v < 4; v++) begin
      if (v > 0) push(vecs[v].data);
      run_frame(vecs[v].name, vecs[v].data, vecs[v].line, 1'b0, w);
    end

    // Back-to-back: the second frame must pop straight away, leaving only
    // the IDLE and CAPTURE high cycles before its start bit.
    push(8'h55);
    push(8'hA3);
    run_frame("b2b 55", 8'h55, 10'h2AA, 1'b0, w);
    run_frame("b2b a3", 8'hA3, 10'h346, 1'b0, w2);
    check("b2b gap", 64'(w2), 64'd0);

    // Empty FIFO for 100 cycles: nothing moves.
    bad   = 0;
    pops0 = pops;
    for (int i = 0; i < 100; i++) begin
      step();
      if ({bus.fifo_rd_en_o, tx_o, busy_o, frame_done_o} !== 4'b0100) bad++;
    end
    check("idle quiet cycles", 64'(bad), 64'd0);
    check("idle no pops", 64'(pops - pops0), 64'd0);

    // Reset during data bit 3 of 0xC3, then 0x7E must go out cleanly.
    push(8'hC3);
    check("c3 rd_en", 64'(bus.fifo_rd_en_o), 64'd1);
    step();
    step();
    for (int i = 0; i < 17; i++) step();
    check("c3 bit3 on line", 64'(tx_o), 64'd0);
    push(8'h7E);
    reset_i = 1'b1;
    #1;
    step();
    check("mid-frame reset busy/tx/done", {busy_o, tx_o, frame_done_o}, 3'b010);
    reset_i = 1'b0;
    #1;
    run_frame("7e", 8'h7E, 10'h2FC, 1'b0, w);
    check("7e pops immediately", 64'(w), 64'd0);

    // Random empty/dout activity mid-frame must not disturb 0x81.
    push(8'h81);
    run_frame("81 noisy", 8'h81, 10'h302, 1'b1, w);
    check("no pop after noisy frame", 64'(bus.fifo_rd_en_o), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
